// File: rtl/frame_pkg.sv
// Shared defaults and FSM encoding for the frame overlap buffer.
package frame_pkg;
   localparam int DEF_FRAME_LEN = 512;
   localparam int DEF_HOP       = 256;
   localparam int DEF_DW        = 16;
   localparam int DEF_DEPTH     = 2 * DEF_FRAME_LEN;
   localparam int ADDR_W        = $clog2(DEF_DEPTH);

   typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/frame_ram.sv
// Simple dual-port sample store: one write port, one synchronous read port.
// Read data appears one cycle after rd_en; only the read register is reset.
module frame_ram #(
   parameter int DEPTH = 1024,
   parameter int DW    = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);
   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/frame_overlap_buffer.sv
// Buffers strobed samples in a circular RAM and replays overlapping FRAME_LEN frames, HOP apart.
// Output lags the read issue by one cycle; no back-pressure, samples are dropped (sticky overrun) when full.
module frame_overlap_buffer
   import frame_pkg::*;
#(
   parameter int FRAME_LEN = DEF_FRAME_LEN,
   parameter int HOP       = DEF_HOP,
   parameter int DW        = DEF_DW,
   parameter int DEPTH     = DEF_DEPTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          out_first,
   output logic          out_last,
   output logic [15:0]   frame_cnt,
   output logic          overrun
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL   = (AW+1)'(DEPTH);
   localparam logic [AW:0]   NEED   = (AW+1)'(FRAME_LEN);
   localparam logic [AW:0]   STEP   = (AW+1)'(HOP);
   localparam logic [AW-1:0] STEP_A = AW'(HOP);
   localparam logic [AW-1:0] LAST   = AW'(FRAME_LEN - 1);

   state_t        state;
   logic [AW-1:0] wp, base, rc, rd_addr;
   logic [AW:0]   avail;
   logic          accept, rd_en;

   assign accept  = in_valid && (avail < FULL);
   assign rd_en   = (state == SEND);
   assign rd_addr = base + rc;

   frame_ram #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (accept),
      .wr_addr (wp),
      .wr_data (in_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (out_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wp        <= '0;
         base      <= '0;
         rc        <= '0;
         avail     <= '0;
         frame_cnt <= '0;
         overrun   <= 1'b0;
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         // Flags track the read issued this cycle, aligned with the RAM's registered data.
         out_valid <= rd_en;
         out_first <= rd_en && (rc == '0);
         out_last  <= rd_en && (rc == LAST);

         if (accept)                wp      <= wp + 1'b1;
         if (in_valid && !accept)   overrun <= 1'b1;

         case (state)
            IDLE: begin
               avail <= avail + (AW+1)'(accept);
               if (avail >= NEED) begin
                  state <= SEND;
                  rc    <= '0;
               end
            end
            SEND: begin
               rc <= rc + 1'b1;
               if (rc == LAST) begin
                  state     <= IDLE;
                  base      <= base + STEP_A;
                  avail     <= avail - STEP + (AW+1)'(accept);
                  frame_cnt <= frame_cnt + 16'd1;
               end else begin
                  avail <= avail + (AW+1)'(accept);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_frame_overlap_buffer.sv
// Directed bench: ramps in, frame summaries collected by a monitor and compared to hand-derived values.
module tb_frame_overlap_buffer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = 16'd0;
   logic        out_valid, out_first, out_last, overrun;
   logic [15:0] out_data, frame_cnt;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int last_wr = 0;

   typedef struct {
      int start;
      int len;
      int seq_err;
      int flag_err;
      int cyc;
   } fsum_t;

   fsum_t       frames[$];
   fsum_t       cur;
   fsum_t       last_f;
   logic        in_frame = 1'b0;
   logic [15:0] prev = 16'd0;

   frame_overlap_buffer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_first (out_first),
      .out_last  (out_last),
      .frame_cnt (frame_cnt),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Collapse each output burst into one summary; a burst cut by reset is discarded.
   always @(negedge clk) begin
      if (rst) begin
         in_frame = 1'b0;
      end else if (out_valid) begin
         if (!in_frame) begin
            in_frame     = 1'b1;
            cur.start    = int'(out_data);
            cur.len      = 0;
            cur.seq_err  = 0;
            cur.flag_err = out_first ? 0 : 1;
            cur.cyc      = cyc;
         end else begin
            if (out_data != prev + 16'd1) cur.seq_err++;
            if (out_first) cur.flag_err++;
         end
         prev = out_data;
         cur.len++;
         if (out_last) begin
            frames.push_back(cur);
            in_frame = 1'b0;
         end
      end else if (in_frame) begin
         cur.flag_err++;
         frames.push_back(cur);
         in_frame = 1'b0;
      end
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic check_frame(input string tag, input int start, input int budget);
      for (int i = 0; i < budget && frames.size() == 0; i++) @(negedge clk);
      if (frames.size() == 0) begin
         check({tag, "_timeout"}, 0, 1);
         return;
      end
      last_f = frames.pop_front();
      check({tag, "_start"},    last_f.start,    start);
      check({tag, "_len"},      last_f.len,      512);
      check({tag, "_seq_err"},  last_f.seq_err,  0);
      check({tag, "_flag_err"}, last_f.flag_err, 0);
   endtask

   // Called at a negedge; the sample is written on the following posedge.
   task automatic push(input int d, input int gap);
      in_valid = 1'b1;
      in_data  = d[15:0];
      last_wr  = cyc + 1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (gap - 1) @(negedge clk);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      frames.delete();
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_data",  out_data,  0);
      check("rst_first", out_first, 0);
      check("rst_last",  out_last,  0);
      check("rst_cnt",   frame_cnt, 0);
      check("rst_ovr",   overrun,   0);
      rst = 1'b0;
      @(negedge clk);

      // Slow ramp: first frame, then the overlapping second frame.
      for (int i = 1; i <= 512; i++) push(i, 20);
      check_frame("f1", 1, 2000);
      check("f1_latency", last_f.cyc - last_wr, 2);
      check("f1_cnt", frame_cnt, 1);
      for (int i = 513; i <= 768; i++) push(i, 20);
      check_frame("f2", 257, 2000);
      check("f2_cnt", frame_cnt, 2);

      // Samples keep arriving while frame 3 streams.
      for (int i = 769; i <= 1280; i++) push(i, 3);
      check_frame("f3", 513, 2000);
      check_frame("f4", 769, 2000);
      check("f4_cnt", frame_cnt, 4);
      check("f4_ovr", overrun, 0);

      // Back-to-back writes fill the RAM exactly as frame 1 ends: sample 1025 is dropped.
      do_reset();
      for (int i = 1; i <= 1024; i++) push(i, 1);
      check("ovr_before", overrun, 0);
      push(1025, 1);
      check("ovr_set", overrun, 1);
      check_frame("o1", 1, 2000);
      check_frame("o2", 257, 2000);
      repeat (20) @(negedge clk);
      check("ovr_sticky", overrun, 1);

      // Reset on the 100th output cycle of a frame.
      do_reset();
      check("rst2_ovr_clr", overrun, 0);
      for (int i = 1; i <= 512; i++) push(i, 1);
      for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
      check("r_started", out_valid, 1);
      repeat (99) @(negedge clk);
      check("r_mid_data", out_data, 100);
      rst = 1'b1;
      #1;
      check("r_valid", out_valid, 0);
      check("r_data",  out_data,  0);
      check("r_first", out_first, 0);
      check("r_last",  out_last,  0);
      check("r_cnt",   frame_cnt, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("r_no_partial", frames.size(), 0);
      @(negedge clk);
      for (int i = 7001; i <= 7512; i++) push(i, 1);
      check_frame("r1", 7001, 2000);
      check("r1_cnt", frame_cnt, 1);

      // Ten frames of a continuous ramp: base and wp wrap past address 1023.
      do_reset();
      for (int i = 1; i <= 2816; i++) push(i, 3);
      for (int k = 0; k < 10; k++) check_frame($sformatf("w%0d", k), 256 * k + 1, 2000);
      check("w_cnt", frame_cnt, 10);
      check("w_ovr", overrun, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
